// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a 16x8 dual-port RAM: clears the RAM
// after reset, then round-robins the write port and the read port separately.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   a_req/a_wr/a_addr/a_wdata  requester A command
//   b_req/b_wr/b_addr/b_wdata  requester B command
//   a_gnt/b_gnt                combinational grants
//   a_rvalid/b_rvalid          registered read-data valid
//   rdata                      read data (pass-through of ram_dout)
//   init_done                  registered, high once the clear has finished
//   ram_we/ram_w_addr/ram_din  RAM write port
//   ram_re/ram_r_addr/ram_dout RAM read port (dout registered by the RAM)
module ram_arbiter #(
  parameter logic [7:0] INIT_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_req,
  input  logic       a_wr,
  input  logic [3:0] a_addr,
  input  logic [7:0] a_wdata,
  input  logic       b_req,
  input  logic       b_wr,
  input  logic [3:0] b_addr,
  input  logic [7:0] b_wdata,
  output logic       a_gnt,
  output logic       b_gnt,
  output logic       a_rvalid,
  output logic       b_rvalid,
  output logic [7:0] rdata,
  output logic       init_done,
  output logic       ram_we,
  output logic       ram_re,
  output logic [3:0] ram_w_addr,
  output logic [3:0] ram_r_addr,
  output logic [7:0] ram_din,
  input  logic [7:0] ram_dout
);

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  // Priority flag encoding: 0 = A, 1 = B.
  localparam logic PRI_A = 1'b0;
  localparam logic PRI_B = 1'b1;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       wpri_q, wpri_d;
  logic       rpri_q, rpri_d;
  logic       a_rv_q, a_rv_d;
  logic       b_rv_q, b_rv_d;
  logic       done_q, done_d;

  logic       run;
  logic       a_wc, b_wc;
  logic       a_rc, b_rc;
  logic       wg_a, wg_b;
  logic       rg_a, rg_b;

  assign run  = (state_q == S_RUN);

  // A requester is a candidate on exactly one port, so it can
  // never collect two grants in one cycle.
  assign a_wc = a_req &  a_wr;
  assign b_wc = b_req &  b_wr;
  assign a_rc = a_req & ~a_wr;
  assign b_rc = b_req & ~b_wr;

  assign wg_a = run & a_wc & (~b_wc | (wpri_q == PRI_A));
  assign wg_b = run & b_wc & (~a_wc | (wpri_q == PRI_B));
  assign rg_a = run & a_rc & (~b_rc | (rpri_q == PRI_A));
  assign rg_b = run & b_rc & (~a_rc | (rpri_q == PRI_B));

  assign a_gnt = wg_a | rg_a;
  assign b_gnt = wg_b | rg_b;

  assign a_rvalid  = a_rv_q;
  assign b_rvalid  = b_rv_q;
  assign init_done = done_q;
  assign rdata     = ram_dout;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_INIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'hF) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q;
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  always_comb begin
    ram_we     = 1'b0;
    ram_w_addr = a_addr;
    ram_din    = a_wdata;
    unique case (1'b1)
      !run: begin
        ram_we     = 1'b1;
        ram_w_addr = cnt_q;
        ram_din    = INIT_VAL;
      end
      wg_a: begin
        ram_we     = 1'b1;
        ram_w_addr = a_addr;
        ram_din    = a_wdata;
      end
      wg_b: begin
        ram_we     = 1'b1;
        ram_w_addr = b_addr;
        ram_din    = b_wdata;
      end
      default: begin
        ram_we = 1'b0;
      end
    endcase
  end

  always_comb begin
    ram_re     = 1'b0;
    ram_r_addr = a_addr;
    unique case (1'b1)
      rg_a: begin
        ram_re     = 1'b1;
        ram_r_addr = a_addr;
      end
      rg_b: begin
        ram_re     = 1'b1;
        ram_r_addr = b_addr;
      end
      default: begin
        ram_re = 1'b0;
      end
    endcase
  end

  // Round robin: the winner hands priority to the other side;
  // an idle port keeps its flag.
  always_comb begin
    wpri_d = wpri_q;
    rpri_d = rpri_q;
    if (wg_a) wpri_d = PRI_B;
    if (wg_b) wpri_d = PRI_A;
    if (rg_a) rpri_d = PRI_B;
    if (rg_b) rpri_d = PRI_A;
  end

  always_comb begin
    a_rv_d = rg_a;
    b_rv_d = rg_b;
    done_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      cnt_q   <= 4'd0;
      wpri_q  <= PRI_A;
      rpri_q  <= PRI_A;
      a_rv_q  <= 1'b0;
      b_rv_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wpri_q  <= wpri_d;
      rpri_q  <= rpri_d;
      a_rv_q  <= a_rv_d;
      b_rv_q  <= b_rv_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural 16x8 RAM, directed stimulus,
// expected read data queued at grant time and checked on rvalid.
module tb_ram_arbiter;

  logic       clk;
  logic       rst_n;
  logic       a_req, a_wr, b_req, b_wr;
  logic [3:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [7:0] rdata;
  logic       init_done;
  logic       ram_we, ram_re;
  logic [3:0] ram_w_addr, ram_r_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;

  logic [7:0] mem [16];

  typedef struct {
    bit         who;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  ram_arbiter #(.INIT_VAL(8'h00)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_req      (a_req),
    .a_wr       (a_wr),
    .a_addr     (a_addr),
    .a_wdata    (a_wdata),
    .b_req      (b_req),
    .b_wr       (b_wr),
    .b_addr     (b_addr),
    .b_wdata    (b_wdata),
    .a_gnt      (a_gnt),
    .b_gnt      (b_gnt),
    .a_rvalid   (a_rvalid),
    .b_rvalid   (b_rvalid),
    .rdata      (rdata),
    .init_done  (init_done),
    .ram_we     (ram_we),
    .ram_re     (ram_re),
    .ram_w_addr (ram_w_addr),
    .ram_r_addr (ram_r_addr),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM with registered read; read-before-write on collision.
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'hEE;
    ram_dout = 8'hEE;
  end

  always @(posedge clk) begin
    if (ram_we) mem[ram_w_addr] <= ram_din;
    if (ram_re) ram_dout <= mem[ram_r_addr];
  end

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic pop_chk(input bit who);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL rvalid_unexp: got rvalid for %0d expected none at %0t",
               who, $time);
    end else begin
      e = exp_q.pop_front();
      chk("rv_who", {7'd0, who}, {7'd0, e.who});
      chk("rdata", rdata, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (a_rvalid) pop_chk(1'b0);
      if (b_rvalid) pop_chk(1'b1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic rq, input logic w, input logic [3:0] ad,
                       input logic [7:0] wd);
    a_req = rq; a_wr = w; a_addr = ad; a_wdata = wd;
  endtask

  task automatic set_b(input logic rq, input logic w, input logic [3:0] ad,
                       input logic [7:0] wd);
    b_req = rq; b_wr = w; b_addr = ad; b_wdata = wd;
  endtask

  task automatic gnt(input string nm, input logic ea, input logic eb);
    #1;
    chk({nm, "_a_gnt"}, {7'd0, a_gnt}, {7'd0, ea});
    chk({nm, "_b_gnt"}, {7'd0, b_gnt}, {7'd0, eb});
  endtask

  task automatic push(input bit who, input logic [7:0] d);
    exp_t e;
    e.who = who;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic init_phase(input string nm);
    for (int i = 0; i < 16; i++) begin
      #1;
      chk({nm, "_done0"}, {7'd0, init_done}, 8'd0);
      chk({nm, "_we"}, {7'd0, ram_we}, 8'd1);
      chk({nm, "_waddr"}, {4'd0, ram_w_addr}, i[7:0]);
      chk({nm, "_din"}, ram_din, 8'h00);
      chk({nm, "_re"}, {7'd0, ram_re}, 8'd0);
      chk({nm, "_gnt"}, {6'd0, a_gnt, b_gnt}, 8'd0);
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    tick();
    tick();
    chk("rst_done", {7'd0, init_done}, 8'd0);
    chk("rst_gnt", {6'd0, a_gnt, b_gnt}, 8'd0);
    chk("rst_re", {7'd0, ram_re}, 8'd0);
    chk("rst_rv", {6'd0, a_rvalid, b_rvalid}, 8'd0);

    // Release; B read waits through INIT.
    rst_n = 1'b1;
    set_b(1, 0, 4'd5, 8'h00);
    init_phase("init1");

    // First RUN cycle: B read of cleared word.
    gnt("run0", 0, 1);
    chk("run0_done", {7'd0, init_done}, 8'd1);
    chk("run0_raddr", {4'd0, ram_r_addr}, 8'd5);
    push(1, 8'h00);
    tick();

    // A writes 5A to 3.
    set_b(0, 0, 0, 0);
    set_a(1, 1, 4'd3, 8'h5A);
    gnt("wr3", 1, 0);
    chk("wr3_we", {7'd0, ram_we}, 8'd1);
    chk("wr3_waddr", {4'd0, ram_w_addr}, 8'd3);
    chk("wr3_din", ram_din, 8'h5A);
    tick();

    // A reads 3.
    set_a(1, 0, 4'd3, 8'h00);
    gnt("rd3", 1, 0);
    chk("rd3_re", {7'd0, ram_re}, 8'd1);
    chk("rd3_raddr", {4'd0, ram_r_addr}, 8'd3);
    push(0, 8'h5A);
    tick();

    // A's rvalid cycle: B quiet; B reads 3 (restores read priority to A).
    set_a(0, 0, 0, 0);
    set_b(1, 0, 4'd3, 8'h00);
    gnt("rd3b", 0, 1);
    chk("rd3b_brv", {7'd0, b_rvalid}, 8'd0);
    chk("rd3b_arv", {7'd0, a_rvalid}, 8'd1);
    push(1, 8'h5A);
    tick();

    // Both hold reads for 4 cycles: A,B,A,B.
    set_a(1, 0, 4'd3, 8'h00);
    set_b(1, 0, 4'd0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        gnt("rr_a", 1, 0);
        push(0, 8'h5A);
      end else begin
        gnt("rr_b", 0, 1);
        push(1, 8'h00);
      end
      tick();
    end

    // Same-address write/read collision returns old data.
    set_a(1, 1, 4'd7, 8'hC3);
    set_b(1, 0, 4'd7, 8'h00);
    gnt("coll", 1, 1);
    push(1, 8'h00);
    tick();
    set_a(0, 0, 0, 0);
    gnt("after", 0, 1);
    push(1, 8'hC3);
    tick();

    // Read in flight, then reset pulse with both writing.
    set_a(1, 1, 4'd1, 8'h11);
    set_b(1, 0, 4'd7, 8'h00);
    gnt("pre", 1, 1);
    tick();
    set_b(1, 1, 4'd2, 8'h22);
    gnt("ww0", 0, 1);
    chk("ww0_brv", {7'd0, b_rvalid}, 8'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_gnt", {6'd0, a_gnt, b_gnt}, 8'd0);
    chk("mid_rv", {6'd0, a_rvalid, b_rvalid}, 8'd0);
    chk("mid_done", {7'd0, init_done}, 8'd0);
    chk("mid_re", {7'd0, ram_re}, 8'd0);
    tick();
    rst_n = 1'b1;
    init_phase("init2");

    // Write priority restarts at A.
    gnt("ww1", 1, 0);
    chk("ww1_waddr", {4'd0, ram_w_addr}, 8'd1);
    chk("ww1_din", ram_din, 8'h11);
    tick();
    set_a(0, 0, 0, 0);
    gnt("ww2", 0, 1);
    chk("ww2_waddr", {4'd0, ram_w_addr}, 8'd2);
    chk("ww2_din", ram_din, 8'h22);
    tick();

    // Clear was redone; post-reset write is visible.
    set_b(0, 0, 0, 0);
    set_a(1, 0, 4'd7, 8'h00);
    gnt("rd7", 1, 0);
    push(0, 8'h00);
    tick();
    set_a(0, 0, 0, 0);
    set_b(1, 0, 4'd1, 8'h00);
    gnt("rd1", 0, 1);
    push(1, 8'h11);
    tick();
    set_b(0, 0, 0, 0);
    tick();
    tick();
    chk("q_empty", exp_q.size()[7:0], 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
